// File: rtl/board_clock_pkg.sv
// board_clock_pkg: divider constants, enable phase positions and reset-sequencer states for board_clock_enable
package board_clock_pkg;
  localparam int CPU_DIV = 6;
  localparam int PSG_DIV = 2;
  localparam int DIV_W = 3;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CPU_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_P = 3'd0;
  localparam logic [DIV_W-1:0] DIV_N = 3'd3;
  localparam logic [DIV_W-1:0] DIV_P_T = 3'd3;
  localparam logic [DIV_W-1:0] DIV_N_T0 = 3'd1;
  localparam logic [DIV_W-1:0] DIV_N_T1 = 3'd4;
  typedef enum logic {HOLD, RUN} seq_state_t;
endpackage

// File: rtl/board_ready_sync.sv
// board_ready_sync: 2-flop synchroniser for an asynchronous level, async active-low reset to 0
module board_ready_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, s1} <= 2'b00;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/board_clock_enable.sv
// board_clock_enable: MSX clock enables from one /6 divider plus sequenced system reset.
// Optional BOARD_CLOCK_TURBO_EN adds TURBO/TURBO_ACTIVE for a 7.16MHz CPU enable pattern.
module board_clock_enable
  import board_clock_pkg::*;
#(
  parameter int RESET_HOLD = 21480,
  parameter int HOLD_W = 15
) (
  input  logic CLK,
  input  logic RESET_n,
  input  logic CLK_READY,
  output logic SYS_RESET_n,
  output logic CE_10M,
  output logic CE_CPU_P,
  output logic CE_CPU_N,
  output logic CE_PSG
`ifdef BOARD_CLOCK_TURBO_EN
  ,
  input  logic TURBO,
  output logic TURBO_ACTIVE
`endif
);
  localparam int PSG_W = $clog2(PSG_DIV);
  localparam logic [PSG_W-1:0] PSG_LAST = PSG_W'(PSG_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  logic [DIV_W-1:0] div;
  logic [PSG_W-1:0] psg_ph;
  logic [HOLD_W-1:0] cnt, cnt_nxt;
  seq_state_t state, state_nxt;
  logic rdy, turbo_act;
  board_ready_sync u_rdy_sync (.clk(CLK), .rst_n(RESET_n), .d(CLK_READY), .q(rdy));
`ifdef BOARD_CLOCK_TURBO_EN
  logic turbo_s;
  board_ready_sync u_turbo_sync (.clk(CLK), .rst_n(RESET_n), .d(TURBO), .q(turbo_s));
  // Speed changes only at the period boundary so no CPU phase is ever cut short.
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) turbo_act <= 1'b0;
    else turbo_act <= state_nxt == RUN && (div == DIV_LAST ? turbo_s : turbo_act);
  assign TURBO_ACTIVE = turbo_act;
`else
  assign turbo_act = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      div <= '0;
      psg_ph <= '0;
      CE_10M <= 1'b0;
      CE_CPU_P <= 1'b0;
      CE_CPU_N <= 1'b0;
      CE_PSG <= 1'b0;
    end else begin
      div <= div == DIV_LAST ? '0 : div + 1'b1;
      psg_ph <= div == DIV_LAST ? (psg_ph == PSG_LAST ? '0 : psg_ph + 1'b1) : psg_ph;
      CE_10M <= !div[0];
      CE_CPU_P <= div == DIV_P || (turbo_act && div == DIV_P_T);
      CE_CPU_N <= turbo_act ? (div == DIV_N_T0 || div == DIV_N_T1) : div == DIV_N;
      CE_PSG <= div == DIV_P && psg_ph == PSG_LAST;
    end
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      state <= HOLD;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  always_comb begin
    state_nxt = state;
    cnt_nxt = '0;
    if (state == HOLD && rdy) begin
      state_nxt = cnt == HOLD_LAST ? RUN : HOLD;
      cnt_nxt = (cnt == HOLD_LAST || &cnt) ? cnt : cnt + 1'b1;
    end
    if (state == RUN && !rdy) state_nxt = HOLD;
  end
  assign SYS_RESET_n = state == RUN;
endmodule

// File: tb/tb_board_clock_enable.sv
// tb_board_clock_enable: randomized self-checking bench against a cycle-count reference model
module tb_board_clock_enable;
  localparam int HOLD = 16;
  logic CLK = 1'b0, RESET_n = 1'b1, CLK_READY = 1'b0, TURBO = 1'b0;
  logic SYS_RESET_n, CE_10M, CE_CPU_P, CE_CPU_N, CE_PSG, TURBO_ACTIVE;
  int total = 0, bad = 0;
  int n, ph, rs, rs1, rs2;
  logic t0, t1, t2;
  logic exp_sys, exp_10m, exp_p, exp_n, exp_psg, exp_ta;
  board_clock_enable #(.RESET_HOLD(HOLD), .HOLD_W(15)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .CLK_READY(CLK_READY), .SYS_RESET_n(SYS_RESET_n),
    .CE_10M(CE_10M), .CE_CPU_P(CE_CPU_P), .CE_CPU_N(CE_CPU_N), .CE_PSG(CE_PSG)
`ifdef BOARD_CLOCK_TURBO_EN
    , .TURBO(TURBO), .TURBO_ACTIVE(TURBO_ACTIVE)
`endif
  );
`ifndef BOARD_CLOCK_TURBO_EN
  assign TURBO_ACTIVE = 1'b0;
`endif
  initial forever #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference: cycle n since release sets every enable; release needs HOLD consecutive
  // ready samples seen through the 2-cycle synchroniser.
  always @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      n = 0; rs = 0; rs1 = 0; rs2 = 0; {t0, t1, t2} = 3'b000;
      {exp_sys, exp_10m, exp_p, exp_n, exp_psg, exp_ta} = 6'b0;
    end else begin
      ph = n % 6;
      n++;
      rs2 = rs1; rs1 = rs; rs = CLK_READY ? rs + 1 : 0;
      t2 = t1; t1 = t0; t0 = TURBO;
      exp_sys = rs2 >= HOLD;
      exp_10m = ph % 2 == 0;
      exp_p = ph == 0 || (exp_ta && ph == 3);
      exp_n = exp_ta ? (ph == 1 || ph == 4) : ph == 3;
      exp_psg = (n - 1) % 12 == 6;
      if (ph == 5) exp_ta = t2;
      if (!exp_sys) exp_ta = 1'b0;
    end
  always @(negedge CLK) begin
    check("sys_reset_n", SYS_RESET_n, exp_sys);
    check("ce_10m", CE_10M, exp_10m);
    check("ce_cpu_p", CE_CPU_P, exp_p);
    check("ce_cpu_n", CE_CPU_N, exp_n);
    check("ce_psg", CE_PSG, exp_psg);
    check("turbo_active", TURBO_ACTIVE, exp_ta);
    check("p_n_excl", CE_CPU_P & CE_CPU_N, 0);
  end
  task automatic step(input int k = 1);
    repeat (k) @(posedge CLK);
    #2;
  endtask
  task automatic do_reset;
    RESET_n = 1'b0;
    #1;
    check("rst_outs", {SYS_RESET_n, CE_10M, CE_CPU_P, CE_CPU_N, CE_PSG, TURBO_ACTIVE}, 0);
    step();
    RESET_n = 1'b1;
  endtask
  task automatic wait_sys(input logic lvl, input string tag, input int want);
    int c = 0;
    do begin
      @(posedge CLK);
      #1;
      c++;
    end while (SYS_RESET_n !== lvl && c < 100);
    check(tag, c, want);
    #1;
  endtask
  initial begin
    int cp, cn, cg, ct;
    step();
    do_reset();
    CLK_READY = 1'b1;
    {cp, cn, cg, ct} = '0;
    @(posedge CLK);
    repeat (1200) begin
      @(negedge CLK);
      cp += int'(CE_CPU_P); cn += int'(CE_CPU_N); cg += int'(CE_PSG); ct += int'(CE_10M);
    end
    check("cnt_p", cp, 200);
    check("cnt_n", cn, 200);
    check("cnt_psg", cg, 100);
    check("cnt_10m", ct, 600);
    step();
    CLK_READY = 1'b0;
    do_reset();
    step(9);
    CLK_READY = 1'b1;
    wait_sys(1'b1, "rise_lat", 18);
    CLK_READY = 1'b0;
    do_reset();
    CLK_READY = 1'b1;
    step(12);
    CLK_READY = 1'b0;
    step();
    CLK_READY = 1'b1;
    wait_sys(1'b1, "glitch_lat", 18);
    step(5);
    CLK_READY = 1'b0;
    wait_sys(1'b0, "fall_lat", 3);
    CLK_READY = 1'b1;
    step(3);
    while (n % 6 != 4) step();
    RESET_n = 1'b0;
    #1;
    check("async_zero", {SYS_RESET_n, CE_10M, CE_CPU_P, CE_CPU_N, CE_PSG, TURBO_ACTIVE}, 0);
    step();
    RESET_n = 1'b1;
    @(posedge CLK);
    #1;
    check("first_p", CE_CPU_P, 1);
    #1;
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) CLK_READY = !CLK_READY;
`ifdef BOARD_CLOCK_TURBO_EN
      if ($urandom_range(0, 29) == 0) TURBO = !TURBO;
`endif
      if ($urandom_range(0, 799) == 0) begin
        RESET_n = 1'b0;
        #1;
        RESET_n = 1'b1;
      end
      step();
    end
`ifdef BOARD_CLOCK_TURBO_EN
    TURBO = 1'b0;
    CLK_READY = 1'b0;
    do_reset();
    CLK_READY = 1'b1;
    wait_sys(1'b1, "t_boot", 18);
    check("t_boot_slow", TURBO_ACTIVE, 0);
    while (n % 6 != 2) step();
    TURBO = 1'b1;
    step(3);
    check("t_not_yet", TURBO_ACTIVE, 0);
    step();
    check("t_switch", TURBO_ACTIVE, 1);
    {cp, cn, cg} = '0;
    repeat (120) begin
      @(negedge CLK);
      cp += int'(CE_CPU_P); cn += int'(CE_CPU_N); cg += int'(CE_PSG);
    end
    check("t_cnt_p", cp, 40);
    check("t_cnt_n", cn, 40);
    check("t_cnt_psg", cg, 10);
    step();
    CLK_READY = 1'b0;
    wait_sys(1'b0, "t_fall", 3);
    check("t_clear", TURBO_ACTIVE, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
